// File: rtl/mcpu_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port CPU memory; strobe G+1, ack G+MEM_LAT+2.
// Requesters hold req until ack; a losing or late requester simply waits, with no abort path.
module mcpu_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_ack,
  output logic [DW-1:0] o_cpu_rdata,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic          o_dbg_ack,
  output logic [DW-1:0] o_dbg_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy,
  output logic          o_owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          grant_dbg;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    grant_dbg    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_cpu_req || i_dbg_req) begin
          // Debug wins only when alone, or when the CPU was served last.
          grant_dbg = i_dbg_req && (!i_cpu_req || !last_owner_q);
          owner_d   = grant_dbg;
          we_d      = grant_dbg ? i_dbg_we    : i_cpu_we;
          addr_d    = grant_dbg ? i_dbg_addr  : i_cpu_addr;
          wdata_d   = grant_dbg ? i_dbg_wdata : i_cpu_wdata;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_q) dbg_rdata_d = i_mem_rdata;
            else         cpu_rdata_d = i_mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign o_mem_en    = (state_q == ACCESS);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_cpu_ack   = (state_q == DONE) && !owner_q;
  assign o_dbg_ack   = (state_q == DONE) && owner_q;
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_dbg_rdata = dbg_rdata_q;
  assign o_busy      = (state_q != IDLE);
  assign o_owner     = owner_q;

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Directed bench: three arbiter instances (MEM_LAT 2, 1, 15) share requester inputs,
// each with its own latency-matched memory model; instance 0 carries most scenarios.
module tb_mcpu_mem_arbiter;

  logic        i_clk;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic        cpu_ack   [3];
  logic        dbg_ack   [3];
  logic [31:0] cpu_rdata [3];
  logic [31:0] dbg_rdata [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic        busy      [3];
  logic        owner     [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cpu_ack_cnt [3];
  int dbg_ack_cnt [3];

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        owner;
  } strobe_t;
  strobe_t strobes[$];

  mcpu_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u_l2 (
    .i_clk(i_clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack[0]), .o_cpu_rdata(cpu_rdata[0]),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(dbg_ack[0]), .o_dbg_rdata(dbg_rdata[0]),
    .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
    .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0]),
    .o_busy(busy[0]), .o_owner(owner[0])
  );

  mcpu_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_l1 (
    .i_clk(i_clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack[1]), .o_cpu_rdata(cpu_rdata[1]),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(dbg_ack[1]), .o_dbg_rdata(dbg_rdata[1]),
    .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
    .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1]),
    .o_busy(busy[1]), .o_owner(owner[1])
  );

  mcpu_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(15)) u_l15 (
    .i_clk(i_clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack[2]), .o_cpu_rdata(cpu_rdata[2]),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(dbg_ack[2]), .o_dbg_rdata(dbg_rdata[2]),
    .o_mem_en(mem_en[2]), .o_mem_we(mem_we[2]), .o_mem_addr(mem_addr[2]),
    .o_mem_wdata(mem_wdata[2]), .i_mem_rdata(mem_rdata[2]),
    .o_busy(busy[2]), .o_owner(owner[2])
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Memory model: stage k of the read pipe is visible k+1 cycles after the strobe.
  logic [31:0] mem [256];
  logic [15:0] pv [3];
  logic [7:0]  pa [3][16];

  always @(posedge i_clk) begin
    if (rst) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'h20202020;
      mem[8'h40] <= 32'hCAFEF00D;
      for (int d = 0; d < 3; d++) pv[d] <= '0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        pv[d] <= {pv[d][14:0], mem_en[d] & ~mem_we[d]};
        for (int k = 15; k > 0; k--) pa[d][k] <= pa[d][k-1];
        pa[d][0] <= mem_addr[d][7:0];
        if (mem_en[d] && mem_we[d]) mem[mem_addr[d][7:0]] <= mem_wdata[d];
      end
    end
  end

  assign mem_rdata[0] = pv[0][1]  ? mem[pa[0][1]]  : 32'hBADC0FFE;
  assign mem_rdata[1] = pv[1][0]  ? mem[pa[1][0]]  : 32'hBADC0FFE;
  assign mem_rdata[2] = pv[2][14] ? mem[pa[2][14]] : 32'hBADC0FFE;

  // Event logger for strobes on instance 0 and ack counts on all instances.
  initial begin
    for (int d = 0; d < 3; d++) begin
      cpu_ack_cnt[d] = 0;
      dbg_ack_cnt[d] = 0;
    end
  end

  always @(negedge i_clk) begin
    if (mem_en[0] === 1'b1)
      strobes.push_back(strobe_t'{cyc, mem_we[0], mem_addr[0], mem_wdata[0], owner[0]});
    for (int d = 0; d < 3; d++) begin
      if (cpu_ack[d] === 1'b1) cpu_ack_cnt[d]++;
      if (dbg_ack[d] === 1'b1) dbg_ack_cnt[d]++;
    end
  end

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge i_clk);
    rst = 0;
  endtask

  // Returns the cycle of the first ack seen within budget, or -1 on timeout.
  task automatic wait_ack(input int d, input bit dbg, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if ((dbg ? dbg_ack[d] : cpu_ack[d]) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_en[0], mem_we[0], cpu_ack[0], dbg_ack[0], busy[0], owner[0]} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: en/we/cack/dack/busy/owner=%b expected 000000",
               {mem_en[0], mem_we[0], cpu_ack[0], dbg_ack[0], busy[0], owner[0]});
    end
    checks++;
    if (mem_addr[0] !== 32'h0 || mem_wdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: addr=%h wdata=%h expected 0/0", mem_addr[0], mem_wdata[0]);
    end
    checks++;
    if (cpu_rdata[0] !== 32'h0 || dbg_rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: cpu=%h dbg=%h expected 0/0", cpu_rdata[0], dbg_rdata[0]);
    end
  endtask

  task automatic test_single_read();
    int g, at, d0;
    strobes.delete();
    d0 = dbg_ack_cnt[0];
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    g = cyc;
    wait_ack(0, 0, 20, at);
    cpu_req = 0;
    checks++;
    if (at !== g + 4) begin
      errors++;
      $display("FAIL single_ack_cycle: got %0d expected %0d", at, g + 4);
    end
    checks++;
    if (cpu_rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_rdata: got %h expected deadbeef", cpu_rdata[0]);
    end
    checks++;
    if (strobes.size() !== 1) begin
      errors++;
      $display("FAIL single_strobe_count: got %0d expected 1", strobes.size());
    end else begin
      checks++;
      if (strobes[0].cyc !== g + 1 || strobes[0].addr !== 32'h10 || strobes[0].we !== 1'b0) begin
        errors++;
        $display("FAIL single_strobe: cyc=%0d addr=%h we=%b expected cyc=%0d addr=10 we=0",
                 strobes[0].cyc, strobes[0].addr, strobes[0].we, g + 1);
      end
    end
    repeat (3) @(negedge i_clk);
    checks++;
    if (dbg_ack_cnt[0] !== d0) begin
      errors++;
      $display("FAIL single_no_dbg_ack: got %0d debug acks expected %0d", dbg_ack_cnt[0], d0);
    end
  endtask

  task automatic test_conflict();
    int g, ac, ad;
    do_reset();
    strobes.delete();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h30; dbg_wdata = 32'h12345678;
    g = cyc;
    wait_ack(0, 0, 20, ac);
    cpu_req = 0;
    wait_ack(0, 1, 20, ad);
    dbg_req = 0;
    checks++;
    if (ac !== g + 4 || ad !== g + 9) begin
      errors++;
      $display("FAIL conflict_ack_order: cpu=%0d dbg=%0d expected %0d/%0d", ac, ad, g + 4, g + 9);
    end
    checks++;
    if (cpu_rdata[0] !== 32'h20202020) begin
      errors++;
      $display("FAIL conflict_cpu_rdata: got %h expected 20202020", cpu_rdata[0]);
    end
    checks++;
    if (strobes.size() !== 2) begin
      errors++;
      $display("FAIL conflict_strobe_count: got %0d expected 2", strobes.size());
    end else begin
      checks++;
      if (strobes[0].owner !== 1'b0 || strobes[0].addr !== 32'h20 || strobes[0].we !== 1'b0) begin
        errors++;
        $display("FAIL conflict_first: owner=%b addr=%h we=%b expected 0/20/0",
                 strobes[0].owner, strobes[0].addr, strobes[0].we);
      end
      checks++;
      if (strobes[1].owner !== 1'b1 || strobes[1].we !== 1'b1 || strobes[1].addr !== 32'h30 ||
          strobes[1].wdata !== 32'h12345678 || strobes[1].cyc - strobes[0].cyc !== 5) begin
        errors++;
        $display("FAIL conflict_second: owner=%b we=%b addr=%h wdata=%h gap=%0d expected 1/1/30/12345678/5",
                 strobes[1].owner, strobes[1].we, strobes[1].addr, strobes[1].wdata,
                 strobes[1].cyc - strobes[0].cyc);
      end
    end

    @(negedge i_clk);
    strobes.delete();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h30;
    g = cyc;
    wait_ack(0, 0, 20, ac);
    cpu_req = 0;
    wait_ack(0, 1, 20, ad);
    dbg_req = 0;
    checks++;
    if (ac !== g + 4 || ad !== g + 9) begin
      errors++;
      $display("FAIL conflict2_ack_order: cpu=%0d dbg=%0d expected %0d/%0d", ac, ad, g + 4, g + 9);
    end
    checks++;
    if (dbg_rdata[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL conflict2_dbg_rdata: got %h expected 12345678", dbg_rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    int g, a1, a2, a3;
    @(negedge i_clk);
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
    g = cyc;
    wait_ack(0, 1, 20, a1);
    wait_ack(0, 1, 20, a2);
    wait_ack(0, 1, 20, a3);
    dbg_req = 0;
    checks++;
    if (a1 !== g + 4) begin
      errors++;
      $display("FAIL b2b_first: got %0d expected %0d", a1, g + 4);
    end
    checks++;
    if (a2 - a1 !== 5 || a3 - a2 !== 5) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d/%0d expected 5/5", a2 - a1, a3 - a2);
    end
    checks++;
    if (dbg_rdata[0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL b2b_rdata: got %h expected cafef00d", dbg_rdata[0]);
    end
  endtask

  task automatic test_write_read();
    int g, aw, ar;
    @(negedge i_clk);
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h50; dbg_wdata = 32'hA5A5A5A5;
    wait_ack(0, 1, 20, aw);
    dbg_req = 0;
    checks++;
    if (aw < 0 || dbg_rdata[0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL wr_keeps_rdata: ack=%0d rdata=%h expected cafef00d", aw, dbg_rdata[0]);
    end
    @(negedge i_clk);
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h50;
    g = cyc;
    repeat (3) @(negedge i_clk);
    checks++;
    if (dbg_rdata[0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rd_early_update: got %h expected cafef00d", dbg_rdata[0]);
    end
    wait_ack(0, 1, 10, ar);
    dbg_req = 0;
    checks++;
    if (ar !== g + 4 || dbg_rdata[0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rd_after_wr: ack=%0d rdata=%h expected %0d/a5a5a5a5", ar, dbg_rdata[0], g + 4);
    end
  endtask

  task automatic test_reset_in_wait();
    int g, at, c0, d0;
    @(negedge i_clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    repeat (2) @(negedge i_clk);
    c0 = cpu_ack_cnt[0];
    d0 = dbg_ack_cnt[0];
    rst = 1;
    cpu_req = 0;
    @(negedge i_clk);
    rst = 0;
    checks++;
    if (busy[0] !== 1'b0 || owner[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_busy: busy=%b owner=%b expected 0/0", busy[0], owner[0]);
    end
    checks++;
    if (cpu_rdata[0] !== 32'h0 || dbg_rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL rstwait_rdata: cpu=%h dbg=%h expected 0/0", cpu_rdata[0], dbg_rdata[0]);
    end
    repeat (20) @(negedge i_clk);
    checks++;
    if (cpu_ack_cnt[0] !== c0 || dbg_ack_cnt[0] !== d0) begin
      errors++;
      $display("FAIL rstwait_no_ack: cpu=%0d dbg=%0d acks expected %0d/%0d",
               cpu_ack_cnt[0], dbg_ack_cnt[0], c0, d0);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    g = cyc;
    wait_ack(0, 0, 20, at);
    cpu_req = 0;
    checks++;
    if (at !== g + 4 || cpu_rdata[0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rstwait_recover: ack=%0d rdata=%h expected %0d/cafef00d", at, cpu_rdata[0], g + 4);
    end
  endtask

  task automatic test_latency();
    int g, a1, a15;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    g = cyc;
    wait_ack(1, 0, 10, a1);
    checks++;
    if (a1 !== g + 3 || cpu_rdata[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lat1: ack=%0d rdata=%h expected %0d/deadbeef", a1, cpu_rdata[1], g + 3);
    end
    wait_ack(2, 0, 30, a15);
    cpu_req = 0;
    checks++;
    if (a15 !== g + 17 || cpu_rdata[2] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lat15: ack=%0d rdata=%h expected %0d/deadbeef", a15, cpu_rdata[2], g + 17);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_conflict();
    test_back_to_back();
    test_write_read();
    test_reset_in_wait();
    test_latency();
    repeat (2) @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
